// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type, stall-cause codes and register-zero constant
package hazard_pkg;
  typedef enum logic {IDLE, MD_BUSY} state_e;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_LU   = 2'd1;
  localparam logic [1:0] CAUSE_BR   = 2'd2;
  localparam logic [1:0] CAUSE_MD   = 2'd3;
  localparam int         REG_ZERO   = 0;
endpackage

// File: rtl/hazard_md_timer.sv
// hazard_md_timer: holds EX for MD_LAT-1 cycles after a mul/div enters EX
// Starts while busy are ignored; MD_LAT == 1 never leaves IDLE.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic start_i,
  output logic busy_o
);
  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MD_LAT > 1) ? CW'(MD_LAT - 2) : '0;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start_i && (MD_LAT > 1)) begin
        state_d = MD_BUSY;
        cnt_d   = CNT_LOAD;
      end
    end else if (cnt_q == '0) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy_o = (state_q == MD_BUSY);
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / branch / mul-div stall and IF/ID flush control
// Optional HAZARD_STATS_EN adds saturating Stall_Cycles and Flush_Count outputs.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] Rs_ID,
  input  logic [REG_AW-1:0] Rt_ID,
  input  logic              UsesRt_ID,
  input  logic              Branch_ID,
  input  logic              BranchTaken_ID,
  input  logic              Jump_ID,
  input  logic              MemRead_EX,
  input  logic              RegWrite_EX,
  input  logic [REG_AW-1:0] Rd_EX,
  input  logic              MulDiv_Start_EX,
  input  logic              MemRead_MEM,
  input  logic [REG_AW-1:0] Rd_MEM,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IDEX_Bubble,
  output logic              IFID_Flush,
  output logic              EX_Hold,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       Stall_Cycles,
  output logic [31:0]       Flush_Count,
`endif
  output logic              Stall,
  output logic [1:0]        Stall_Cause
);
  logic md_busy, m_ex, m_mem, lu, br, stalled;
  logic [1:0] cause;
  hazard_md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .start_i (MulDiv_Start_EX),
    .busy_o  (md_busy)
  );
  function automatic logic reg_match(input logic [REG_AW-1:0] r, rs, rt, input logic use_rt);
    return (r != REG_AW'(REG_ZERO)) && ((r == rs) || (use_rt && (r == rt)));
  endfunction
  assign m_ex  = reg_match(Rd_EX, Rs_ID, Rt_ID, UsesRt_ID);
  assign m_mem = reg_match(Rd_MEM, Rs_ID, Rt_ID, UsesRt_ID);
  assign lu    = MemRead_EX && RegWrite_EX && m_ex;
  assign br    = Branch_ID && ((RegWrite_EX && m_ex) || (MemRead_MEM && m_mem));
  // Reset overrides everything: hold PC/IF-ID and keep bubbling ID/EX.
  assign cause = !Rst_n  ? CAUSE_NONE :
                 md_busy ? CAUSE_MD   :
                 lu      ? CAUSE_LU   :
                 br      ? CAUSE_BR   : CAUSE_NONE;
  assign stalled     = (cause != CAUSE_NONE);
  assign Stall_Cause = cause;
  assign Stall       = stalled;
  assign PC_Write    = Rst_n && !stalled;
  assign IFID_Write  = Rst_n && !stalled;
  assign IDEX_Bubble = !Rst_n || (cause == CAUSE_LU) || (cause == CAUSE_BR);
  assign EX_Hold     = (cause == CAUSE_MD);
  assign IFID_Flush  = Rst_n && !stalled && (Jump_ID || (Branch_ID && BranchTaken_ID));
`ifdef HAZARD_STATS_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Stall_Cycles <= '0;
      Flush_Count  <= '0;
    end else begin
      if (stalled && !(&Stall_Cycles)) Stall_Cycles <= Stall_Cycles + 1'b1;
      if (IFID_Flush && !(&Flush_Count)) Flush_Count <= Flush_Count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: table-driven combinational vectors plus multi-cycle sequences
module tb_hazard_control_unit;
  logic Clk = 1'b0, Rst_n = 1'b0;
  logic [4:0] Rs_ID, Rt_ID, Rd_EX, Rd_MEM;
  logic UsesRt_ID, Branch_ID, BranchTaken_ID, Jump_ID, MemRead_EX, RegWrite_EX;
  logic MulDiv_Start_EX, MemRead_MEM;
  logic PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, EX_Hold, Stall;
  logic [1:0] Stall_Cause;
`ifdef HAZARD_STATS_EN
  logic [31:0] Stall_Cycles, Flush_Count;
`endif
  int n_chk = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  hazard_control_unit #(.REG_AW(5), .MD_LAT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
    .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID), .Jump_ID(Jump_ID),
    .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .Rd_EX(Rd_EX),
    .MulDiv_Start_EX(MulDiv_Start_EX), .MemRead_MEM(MemRead_MEM), .Rd_MEM(Rd_MEM),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .EX_Hold(EX_Hold),
`ifdef HAZARD_STATS_EN
    .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count),
`endif
    .Stall(Stall), .Stall_Cause(Stall_Cause)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       ut, br, bt, j, mre, rwe;
    logic [4:0] rde;
    logic       mrm;
    logic [4:0] rdm;
    logic       pcw, bub, fl;
    logic [1:0] cause;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pcw, input logic bub, input logic fl,
                         input logic hold, input logic [1:0] cause);
    chk({tag, ".PC_Write"}, 32'(PC_Write), 32'(pcw));
    chk({tag, ".IFID_Write"}, 32'(IFID_Write), 32'(pcw));
    chk({tag, ".IDEX_Bubble"}, 32'(IDEX_Bubble), 32'(bub));
    chk({tag, ".IFID_Flush"}, 32'(IFID_Flush), 32'(fl));
    chk({tag, ".EX_Hold"}, 32'(EX_Hold), 32'(hold));
    chk({tag, ".Stall_Cause"}, 32'(Stall_Cause), 32'(cause));
    chk({tag, ".Stall"}, 32'(Stall), 32'(cause != 2'd0));
  endtask

  task automatic clear_in();
    Rs_ID = 0; Rt_ID = 0; Rd_EX = 0; Rd_MEM = 0; UsesRt_ID = 0; Branch_ID = 0;
    BranchTaken_ID = 0; Jump_ID = 0; MemRead_EX = 0; RegWrite_EX = 0;
    MulDiv_Start_EX = 0; MemRead_MEM = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    //            name        rs rt ut br bt j mre rwe rde mrm rdm pcw bub fl cause
    tbl[0]  = '{"lu_rs",      2, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1, 0, 2'd1};
    tbl[1]  = '{"lu_rt",      5, 2, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1, 0, 2'd1};
    tbl[2]  = '{"rt_unused",  5, 2, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0, 0, 2'd0};
    tbl[3]  = '{"rd_zero",    0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 2'd0};
    tbl[4]  = '{"br_ex",      4, 9, 1, 1, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 2'd2};
    tbl[5]  = '{"br_mem",     6, 7, 1, 1, 0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 2'd2};
    tbl[6]  = '{"alu_fwd",    4, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 2'd0};
    tbl[7]  = '{"br_taken",   1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0};
    tbl[8]  = '{"jump",       0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0};
    tbl[9]  = '{"jump_lu",    3, 0, 0, 0, 0, 1, 1, 1, 3, 0, 0, 0, 1, 0, 2'd1};
    tbl[10] = '{"mem_nobr",   7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 2'd0};
    tbl[11] = '{"ld_nowr",    2, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 0, 0, 2'd0};
    tbl[12] = '{"br_tk_stall",8, 0, 0, 1, 1, 0, 0, 1, 8, 0, 0, 0, 1, 0, 2'd2};

    clear_in();
    Jump_ID = 1; MulDiv_Start_EX = 1;
    #2 chk_out("reset", 0, 1, 0, 0, 2'd0);
    step(); step();
    clear_in();
    Rst_n = 1;
    #2 chk_out("post_reset", 1, 0, 0, 0, 2'd0);
    step();

    for (int i = 0; i < 13; i++) begin
      Rs_ID = tbl[i].rs; Rt_ID = tbl[i].rt; UsesRt_ID = tbl[i].ut; Branch_ID = tbl[i].br;
      BranchTaken_ID = tbl[i].bt; Jump_ID = tbl[i].j; MemRead_EX = tbl[i].mre;
      RegWrite_EX = tbl[i].rwe; Rd_EX = tbl[i].rde; MemRead_MEM = tbl[i].mrm; Rd_MEM = tbl[i].rdm;
      #2 chk_out(tbl[i].name, tbl[i].pcw, tbl[i].bub, tbl[i].fl, 1'b0, tbl[i].cause);
      step();
    end

    // load then dependent branch: LU, BR via MEM, then taken flush for one cycle
    clear_in();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 3; Branch_ID = 1; Rs_ID = 3; Rt_ID = 4; UsesRt_ID = 1;
    #2 chk_out("ldbr_c1", 0, 1, 0, 0, 2'd1);
    step();
    MemRead_EX = 0; RegWrite_EX = 0; Rd_EX = 0; MemRead_MEM = 1; Rd_MEM = 3;
    #2 chk_out("ldbr_c2", 0, 1, 0, 0, 2'd2);
    step();
    MemRead_MEM = 0; Rd_MEM = 0; BranchTaken_ID = 1;
    #2 chk_out("ldbr_c3", 1, 0, 1, 0, 2'd0);
    step();
    clear_in();
    #2 chk_out("ldbr_c4", 1, 0, 0, 0, 2'd0);
    step();

    // mul/div hold of MD_LAT-1 cycles with a masked load-use and an ignored restart
    MulDiv_Start_EX = 1;
    #2 chk_out("md_start", 1, 0, 0, 0, 2'd0);
    step();
    MulDiv_Start_EX = 0; MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 2; Rs_ID = 2;
    #2 chk_out("md_h1", 0, 0, 0, 1, 2'd3);
    step();
    MulDiv_Start_EX = 1;
    #2 chk_out("md_h2", 0, 0, 0, 1, 2'd3);
    step();
    MulDiv_Start_EX = 0;
    #2 chk_out("md_h3", 0, 0, 0, 1, 2'd3);
    step();
    #2 chk_out("md_lu_after", 0, 1, 0, 0, 2'd1);
    step();
    clear_in();
    #2 chk_out("md_done", 1, 0, 0, 0, 2'd0);
    step();

    // asynchronous reset in the second busy cycle
    MulDiv_Start_EX = 1;
    step();
    MulDiv_Start_EX = 0;
    step();
    #1 chk_out("mdr_h2", 0, 0, 0, 1, 2'd3);
    Jump_ID = 1;
    #1 Rst_n = 0;
    #1 chk_out("mdr_rst", 0, 1, 0, 0, 2'd0);
    Jump_ID = 0;
    step();
    #1 Rst_n = 1;
    #1 chk_out("mdr_rel", 1, 0, 0, 0, 2'd0);
    step();
    #1 chk_out("mdr_nohold", 1, 0, 0, 0, 2'd0);

    // jump alongside a branch stall: flush deferred to the first unstalled cycle
    clear_in();
    Jump_ID = 1; Branch_ID = 1; RegWrite_EX = 1; Rd_EX = 4; Rs_ID = 4;
    #1 chk_out("jbr_stall", 0, 1, 0, 0, 2'd2);
    step();
    RegWrite_EX = 0; Rd_EX = 0; Branch_ID = 0;
    #2 chk_out("jbr_free", 1, 0, 1, 0, 2'd0);
    step();
    clear_in();
    #2 chk_out("jbr_idle", 1, 0, 0, 0, 2'd0);
`ifdef HAZARD_STATS_EN
    chk("stall_cycles", Stall_Cycles, 32'd1);
    chk("flush_count", Flush_Count, 32'd1);
`endif
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
